// File: rtl/normalizer_pkg.sv
// Shared types and width helpers for the coefficient normalizers.
package normalizer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a carry out of one step: the coefficient plus the previous
    // carry fits in BIT_LEN+1 bits, and WORD_LEN of those bits leave as the limb.
    function automatic int carry_len(input int bit_len, input int word_len);
        return bit_len - word_len + 1;
    endfunction

    // Index width, with a minimum of one bit so that a single-element build still has a port.
    function automatic int idx_len(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/normalize_step.sv
// One carry-propagate step: coefficient + incoming carry, split into limb and carry.
module normalize_step
    import normalizer_pkg::*;
#(
    parameter int BIT_LEN   = 16,
    parameter int WORD_LEN  = 8,
    parameter int CARRY_LEN = carry_len(BIT_LEN, WORD_LEN)
) (
    input  logic [BIT_LEN-1:0]   term,
    input  logic [CARRY_LEN-1:0] carry_in,
    output logic [WORD_LEN-1:0]  limb,
    output logic [CARRY_LEN-1:0] carry_out
);

    logic [BIT_LEN:0] acc;

    // Carry is narrower than the term, so the BIT_LEN+1 wide sum cannot overflow.
    assign acc       = {1'b0, term} + {{WORD_LEN{1'b0}}, carry_in};
    assign limb      = acc[WORD_LEN-1:0];
    assign carry_out = acc[BIT_LEN:WORD_LEN];

endmodule

// File: rtl/coeff_normalizer_seq.sv
// Limb-serial carry-propagate normalizer for redundant-form coefficient vectors.
//
//   state | meaning
//   IDLE  | waiting for a vector; in_ready high
//   RUN   | presenting limb idx; advances on each out_ready handshake
module coeff_normalizer_seq
    import normalizer_pkg::*;
#(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = 16,
    parameter int WORD_LEN     = 8,
    localparam int CARRY_LEN   = carry_len(BIT_LEN, WORD_LEN),
    localparam int IDX_LEN     = idx_len(NUM_ELEMENTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_LEN-1:0]   terms [NUM_ELEMENTS],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_LEN-1:0]  out_limb,
    output logic [IDX_LEN-1:0]   out_idx,
    output logic                 out_last,
    output logic [CARRY_LEN-1:0] out_carry
);

    state_t               state, state_n;
    logic [IDX_LEN-1:0]   idx;
    logic [CARRY_LEN-1:0] carry_q;
    logic [BIT_LEN-1:0]   term_q [NUM_ELEMENTS];

    logic [BIT_LEN-1:0]   cur_term;
    logic [WORD_LEN-1:0]  step_limb;
    logic [CARRY_LEN-1:0] step_carry;
    logic                 is_last;
    logic                 accept;
    logic                 advance;

    // Select the coefficient for the current limb; explicit compare keeps the
    // unused index codes (idx beyond NUM_ELEMENTS-1) well defined.
    always_comb begin
        cur_term = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (idx == IDX_LEN'(i)) begin
                cur_term = term_q[i];
            end
        end
    end

    normalize_step #(
        .BIT_LEN   (BIT_LEN),
        .WORD_LEN  (WORD_LEN),
        .CARRY_LEN (CARRY_LEN)
    ) u_step (
        .term      (cur_term),
        .carry_in  (carry_q),
        .limb      (step_limb),
        .carry_out (step_carry)
    );

    assign is_last = (idx == IDX_LEN'(NUM_ELEMENTS - 1));

    // Next state and handshake outputs; reset forces every output quiet in the same cycle.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_limb  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_carry = '0;
        accept    = 1'b0;
        advance   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    accept   = in_valid;
                    if (in_valid) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    out_valid = 1'b1;
                    out_limb  = step_limb;
                    out_idx   = idx;
                    out_last  = is_last;
                    out_carry = is_last ? step_carry : '0;
                    advance   = out_ready;
                    if (out_ready && is_last) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register, limb index, running carry and captured coefficients.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                term_q[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (accept) begin
                idx     <= '0;
                carry_q <= '0;
                for (int i = 0; i < NUM_ELEMENTS; i++) begin
                    term_q[i] <= terms[i];
                end
            end else if (advance) begin
                if (is_last) begin
                    idx     <= '0;
                    carry_q <= '0;
                end else begin
                    idx     <= idx + IDX_LEN'(1);
                    carry_q <= step_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_coeff_normalizer_seq.sv
// Directed bench for coeff_normalizer_seq (9 x 16-bit coefficients, 8-bit limbs).
module tb_coeff_normalizer_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] terms [9];
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_limb;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [8:0]  out_carry;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] vec   [9];
    logic [7:0]  exp_l [9];

    coeff_normalizer_seq #(
        .NUM_ELEMENTS (9),
        .BIT_LEN      (16),
        .WORD_LEN     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .terms     (terms),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_limb  (out_limb),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one vector and hold in_valid for exactly the accepting edge.
    task automatic send(input logic [15:0] v [9], input string tag);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) terms[i] = v[i];
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Collect all limbs of one vector; optional backpressure pattern 1,0,0,1,0 repeating,
    // with a stray in_valid pulse (and changed terms) while RUN is active.
    task automatic drain(input logic [7:0] el [9], input logic [8:0] ec, input bit bp,
                         input string tag);
        int         k       = 0;
        int         cyc     = 0;
        bit         stalled = 1'b0;
        logic [7:0] held_limb = '0;
        logic [3:0] held_idx  = '0;
        logic [4:0] pat       = 5'b01001;
        while (k < 9 && cyc < 100) begin
            out_ready = bp ? pat[cyc % 5] : 1'b1;
            if (bp && cyc == 2) begin
                in_valid = 1'b1;
                for (int i = 0; i < 9; i++) terms[i] = 16'h0000;
            end
            if (bp && cyc == 3) in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("%s_valid_c%0d", tag, cyc), 32'(out_valid), 32'd1);
            check($sformatf("%s_in_ready_c%0d", tag, cyc), 32'(in_ready), 32'd0);
            check($sformatf("%s_idx_c%0d", tag, cyc), 32'(out_idx), 32'(k));
            check($sformatf("%s_limb%0d", tag, k), 32'(out_limb), 32'(el[k]));
            check($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == 8));
            check($sformatf("%s_carry%0d", tag, k), 32'(out_carry),
                  (k == 8) ? 32'(ec) : 32'd0);
            if (stalled) begin
                check($sformatf("%s_stall_limb_c%0d", tag, cyc), 32'(out_limb), 32'(held_limb));
                check($sformatf("%s_stall_idx_c%0d", tag, cyc), 32'(out_idx), 32'(held_idx));
            end
            if (out_ready) begin
                k++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_limb = out_limb;
                held_idx  = out_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (k < 9) check({tag, "_timeout"}, 32'(k), 32'd9);
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) terms[i] = 16'h0;

        // Reset: every output quiet
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_limb", 32'(out_limb), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // All 0x00FF: no carries at all
        for (int i = 0; i < 9; i++) begin vec[i] = 16'h00FF; exp_l[i] = 8'hFF; end
        send(vec, "ff");
        drain(exp_l, 9'h000, 1'b0, "ff");

        // All 0xFFFF: carry grows to 0x100 and stays there
        for (int i = 0; i < 9; i++) begin vec[i] = 16'hFFFF; exp_l[i] = 8'hFF; end
        exp_l[1] = 8'hFE;
        send(vec, "ffff");
        drain(exp_l, 9'h100, 1'b0, "ffff");

        // Single low coefficient spills its high byte into limb 1
        for (int i = 0; i < 9; i++) begin vec[i] = 16'h0000; exp_l[i] = 8'h00; end
        vec[0] = 16'h1234; exp_l[0] = 8'h34; exp_l[1] = 8'h12;
        send(vec, "x1234");
        drain(exp_l, 9'h000, 1'b0, "x1234");

        // Backpressure with the 0xFFFF vector
        for (int i = 0; i < 9; i++) begin vec[i] = 16'hFFFF; exp_l[i] = 8'hFF; end
        exp_l[1] = 8'hFE;
        send(vec, "bp");
        drain(exp_l, 9'h100, 1'b1, "bp");
        out_ready = 1'b1;

        // Reset one cycle after idx 4 is presented
        send(vec, "mid");
        begin
            int budget = 0;
            @(negedge clk);
            while (!(out_valid && out_idx == 4'd4) && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("mid_reach_idx4", 32'(out_idx), 32'd4);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_after_valid", 32'(out_valid), 32'd0);
        check("mid_after_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin vec[i] = 16'h0001; exp_l[i] = 8'h01; end
        send(vec, "ones");
        drain(exp_l, 9'h000, 1'b0, "ones");

        // Back-to-back: in_valid held high, second vector waiting during the first
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) terms[i] = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) terms[i] = 16'h0000;
        terms[0] = 16'h1234;
        for (int i = 0; i < 9; i++) exp_l[i] = 8'hFF;
        exp_l[1] = 8'hFE;
        drain(exp_l, 9'h100, 1'b0, "b2b_a");
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) exp_l[i] = 8'h00;
        exp_l[0] = 8'h34; exp_l[1] = 8'h12;
        drain(exp_l, 9'h000, 1'b0, "b2b_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
